// File: rtl/mux_nto1_val_pipe_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mux_nto1_val_pipe_pkg
//  Description : Shared types and helpers for the valid-gated N-to-1 mux
//                family (stage record, select range check).
//  Revision    : 1.0  initial release
// ============================================================================
package mux_nto1_val_pipe_pkg;

    localparam int DEF_DATA_WIDTH = 8;

    // One pipeline stage record: beat valid, selected data, select error.
    typedef struct packed {
        logic                      valid;
        logic [DEF_DATA_WIDTH-1:0] data;
        logic                      err;
    } stage_t;

    // True when a select value addresses an existing lane.
    function automatic logic sel_in_range(input int unsigned sel,
                                          input int unsigned num_in);
        return (sel < num_in);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mux_nto1_val_pipe_pipe_stage_val.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_stage_val
//  Description : Single valid/data/err register stage. Loads when i_load is
//                high, otherwise holds. Data and err are forced to zero when
//                the loaded beat is not valid, so an empty stage never shows
//                stale data.
//  Revision    : 1.0  initial release
// ============================================================================
module pipe_stage_val #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_load,
    input  logic                  i_valid,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic                  i_err,
    output logic                  o_valid,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_err
);

    logic                  r_valid;
    logic [DATA_WIDTH-1:0] r_data;
    logic                  r_err;

    // Stage register: clear on reset, load with valid-gated zeroing, else hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_err   <= 1'b0;
        end else if (i_load) begin
            r_valid <= i_valid;
            r_data  <= i_valid ? i_data : '0;
            r_err   <= i_valid & i_err;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;
    assign o_err   = r_err;

endmodule
`default_nettype wire

// File: rtl/mux_nto1_val_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : mux_nto1_val_pipe
//  Description : N-to-1 lane selector feeding a valid/ready elastic pipeline
//                of PIPE_DEPTH stages. Out-of-range selects yield a zero beat
//                flagged with sel_err; empty stages are filled regardless of
//                downstream ready so bubbles collapse.
//  Revision    : 1.0  initial release
// ============================================================================
module mux_nto1_val_pipe
    import mux_nto1_val_pipe_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int NUM_IN     = 3,
    parameter int SEL_WIDTH  = $clog2(NUM_IN),
    parameter int PIPE_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] vec [NUM_IN-1:0],
    input  logic [SEL_WIDTH-1:0]  sel,
    input  logic                  in_val,
    output logic                  in_rdy,
    output logic [DATA_WIDTH-1:0] out,
    output logic                  out_val,
    input  logic                  out_rdy,
    output logic                  sel_err,
    output logic                  err_sticky
);

    localparam int c_HEAD = PIPE_DEPTH - 1;

    logic [DATA_WIDTH-1:0] w_sel_data;
    logic                  w_sel_err;
    logic [PIPE_DEPTH-1:0] w_adv;
    logic [PIPE_DEPTH-1:0] w_stg_valid;
    logic [PIPE_DEPTH-1:0] w_stg_err;
    logic [DATA_WIDTH-1:0] w_stg_data [PIPE_DEPTH];
    logic                  r_err_sticky;

    // Lane select: zero unless in_val; out-of-range select gives zero + err.
    always_comb begin
        w_sel_data = '0;
        w_sel_err  = 1'b0;
        if (in_val) begin
            if (sel_in_range(32'(sel), NUM_IN)) begin
                for (int i = 0; i < NUM_IN; i++) begin
                    if (sel == SEL_WIDTH'(i)) begin
                        w_sel_data = vec[i];
                    end
                end
            end else begin
                w_sel_err = 1'b1;
            end
        end
    end

    // Advance chain: a stage may load when it is empty or its successor moves.
    always_comb begin
        w_adv         = '0;
        w_adv[c_HEAD] = ~w_stg_valid[c_HEAD] | out_rdy;
        for (int k = PIPE_DEPTH - 2; k >= 0; k--) begin
            w_adv[k] = ~w_stg_valid[k] | w_adv[k+1];
        end
    end

    for (genvar k = 0; k < PIPE_DEPTH; k++) begin : g_stage
        logic                  w_ld_valid;
        logic [DATA_WIDTH-1:0] w_ld_data;
        logic                  w_ld_err;

        if (k == 0) begin : g_input
            assign w_ld_valid = in_val & w_adv[0];
            assign w_ld_data  = w_sel_data;
            assign w_ld_err   = w_sel_err;
        end else begin : g_chain
            assign w_ld_valid = w_stg_valid[k-1];
            assign w_ld_data  = w_stg_data[k-1];
            assign w_ld_err   = w_stg_err[k-1];
        end

        pipe_stage_val #(
            .DATA_WIDTH (DATA_WIDTH)
        ) u_stage (
            .clk     (clk),
            .rst     (reset),
            .i_load  (w_adv[k]),
            .i_valid (w_ld_valid),
            .i_data  (w_ld_data),
            .i_err   (w_ld_err),
            .o_valid (w_stg_valid[k]),
            .o_data  (w_stg_data[k]),
            .o_err   (w_stg_err[k])
        );
    end

    // Sticky error: set by any accepted out-of-range beat, cleared by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_err_sticky <= 1'b0;
        end else if (in_val & w_adv[0] & w_sel_err) begin
            r_err_sticky <= 1'b1;
        end
    end

    assign in_rdy     = w_adv[0];
    assign out        = w_stg_data[c_HEAD];
    assign out_val    = w_stg_valid[c_HEAD];
    assign sel_err    = w_stg_err[c_HEAD];
    assign err_sticky = r_err_sticky;

endmodule
`default_nettype wire

// File: tb/tb_mux_nto1_val_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mux_nto1_val_pipe
//  Description : Scoreboard bench for mux_nto1_val_pipe (8-bit, 3 lanes,
//                depth 2). Accepted beats push an expected record; a monitor
//                pops and compares on every output transfer.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mux_nto1_val_pipe;
    import mux_nto1_val_pipe_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] vec [2:0];
    logic [1:0] sel;
    logic       in_val;
    logic       in_rdy;
    logic [7:0] out;
    logic       out_val;
    logic       out_rdy;
    logic       sel_err;
    logic       err_sticky;

    int     checks = 0;
    int     errors = 0;
    stage_t sb [$];

    mux_nto1_val_pipe #(
        .DATA_WIDTH (8),
        .NUM_IN     (3),
        .PIPE_DEPTH (2)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .vec        (vec),
        .sel        (sel),
        .in_val     (in_val),
        .in_rdy     (in_rdy),
        .out        (out),
        .out_val    (out_val),
        .out_rdy    (out_rdy),
        .sel_err    (sel_err),
        .err_sticky (err_sticky)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Hand table for lanes 0x11/0x22/0x33; select 3 is out of range.
    function automatic stage_t exp_of(input logic [1:0] s);
        case (s)
            2'd0:    return '{valid: 1'b1, data: 8'h11, err: 1'b0};
            2'd1:    return '{valid: 1'b1, data: 8'h22, err: 1'b0};
            2'd2:    return '{valid: 1'b1, data: 8'h33, err: 1'b0};
            default: return '{valid: 1'b1, data: 8'h00, err: 1'b1};
        endcase
    endfunction

    // Drive one cycle of inputs; at the negedge record an accepted beat.
    task automatic drive(input logic iv, input logic [1:0] s, input logic ordy);
        in_val  = iv;
        sel     = s;
        out_rdy = ordy;
        @(negedge clk);
        if (in_val && in_rdy && !reset) sb.push_back(exp_of(sel));
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    // Monitor: no X, zero when idle, ordered match on each output transfer.
    always @(negedge clk) begin
        if (!reset) begin
            chk("no_x", 32'($isunknown({out, out_val, sel_err, in_rdy, err_sticky})), 32'd0);
            if (!out_val) chk("idle_zero", 32'({out, sel_err}), 32'd0);
            if (out_val && out_rdy) begin
                if (sb.size() == 0) begin
                    chk("sb_underflow", 32'd1, 32'd0);
                end else begin
                    stage_t e;
                    e = sb.pop_front();
                    chk("sb_data", 32'(out), 32'(e.data));
                    chk("sb_err", 32'(sel_err), 32'(e.err));
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec[0] = 8'h11; vec[1] = 8'h22; vec[2] = 8'h33;
        reset = 1'b1; in_val = 1'b0; sel = 2'd0; out_rdy = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        chk("rst_out", 32'(out), 32'd0);
        chk("rst_out_val", 32'(out_val), 32'd0);
        chk("rst_sel_err", 32'(sel_err), 32'd0);
        chk("rst_sticky", 32'(err_sticky), 32'd0);
        chk("rst_in_rdy", 32'(in_rdy), 32'd1);

        // 1. basic latency
        drive(1'b1, 2'd1, 1'b1); chk("lat_c0_val", 32'(out_val), 32'd0); adv();
        drive(1'b0, 2'd0, 1'b1); chk("lat_c1_val", 32'(out_val), 32'd0); adv();
        drive(1'b0, 2'd0, 1'b1);
        chk("lat_c2_val", 32'(out_val), 32'd1);
        chk("lat_c2_out", 32'(out), 32'h22);
        chk("lat_c2_err", 32'(sel_err), 32'd0);
        adv();
        drive(1'b0, 2'd0, 1'b1); chk("lat_c3_val", 32'(out_val), 32'd0); adv();

        // 2. out-of-range select
        drive(1'b1, 2'd3, 1'b1); chk("oor_sticky_pre", 32'(err_sticky), 32'd0); adv();
        drive(1'b0, 2'd3, 1'b1); chk("oor_sticky_set", 32'(err_sticky), 32'd1); adv();
        drive(1'b0, 2'd0, 1'b1);
        chk("oor_val", 32'(out_val), 32'd1);
        chk("oor_out", 32'(out), 32'd0);
        chk("oor_err", 32'(sel_err), 32'd1);
        adv();
        drive(1'b0, 2'd3, 1'b1); chk("oor_sticky_hold", 32'(err_sticky), 32'd1); adv();

        // 3. backpressure
        drive(1'b1, 2'd0, 1'b0); chk("bp_rdy0", 32'(in_rdy), 32'd1); adv();
        drive(1'b1, 2'd1, 1'b0); chk("bp_rdy1", 32'(in_rdy), 32'd1); adv();
        drive(1'b1, 2'd2, 1'b0); chk("bp_full", 32'(in_rdy), 32'd0); adv();
        drive(1'b1, 2'd2, 1'b1); chk("bp_o0", 32'(out), 32'h11); adv();
        drive(1'b0, 2'd0, 1'b1); chk("bp_o1", 32'(out), 32'h22); adv();
        drive(1'b0, 2'd0, 1'b1); chk("bp_o2", 32'(out), 32'h33); adv();
        drive(1'b0, 2'd0, 1'b1); chk("bp_empty", 32'(out_val), 32'd0); adv();

        // 4. bubble collapse
        drive(1'b1, 2'd0, 1'b0); adv();
        drive(1'b0, 2'd0, 1'b0); adv();
        drive(1'b1, 2'd1, 1'b0); chk("bub_rdy", 32'(in_rdy), 32'd1); adv();
        drive(1'b0, 2'd0, 1'b0);
        chk("bub_full", 32'(in_rdy), 32'd0);
        chk("bub_head", 32'(out), 32'h11);
        adv();
        drive(1'b0, 2'd0, 1'b1); adv();
        drive(1'b0, 2'd0, 1'b1); chk("bub_second", 32'(out), 32'h22); adv();

        // 5. reset mid-flight (err_sticky is still set from test 2)
        drive(1'b1, 2'd0, 1'b0); adv();
        drive(1'b1, 2'd2, 1'b0); adv();
        reset = 1'b1; in_val = 1'b0;
        @(negedge clk);
        sb.delete();
        adv();
        reset = 1'b0;
        drive(1'b0, 2'd0, 1'b1);
        chk("mid_rst_val", 32'(out_val), 32'd0);
        chk("mid_rst_out", 32'(out), 32'd0);
        chk("mid_rst_err", 32'(sel_err), 32'd0);
        chk("mid_rst_sticky", 32'(err_sticky), 32'd0);
        chk("mid_rst_rdy", 32'(in_rdy), 32'd1);
        adv();

        // 6. random traffic against the scoreboard, then drain
        for (int i = 0; i < 3000; i++) begin
            drive(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                  1'($urandom_range(0, 1)));
            adv();
        end
        for (int i = 0; i < 20 && sb.size() != 0; i++) begin
            drive(1'b0, 2'd0, 1'b1);
            adv();
        end
        chk("drain_empty", 32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
